// File: rtl/catalan_seq_ctrl.sv
// catalan_seq_ctrl
//   Iterative Catalan-number engine. It computes C(n) with the recurrence
//   C(0)=1, C(k+1) = C(k)*(4k+2)/(k+2). Each step is one multiply cycle,
//   PW cycles of bit-serial restoring division, and one check cycle.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous reset, active-high
//   start   in   request; accepted only while idle
//   n       in   pair count, sampled on the accept edge
//   busy    out  high while a computation is in progress
//   done    out  one-cycle pulse; result/ovf are valid from this cycle
//   result  out  C(n), or all-ones on overflow
//   ovf     out  C(n) (or an intermediate C(k)) does not fit in W bits
//
// catalan_seq_ctrl_chk is a passive checker. It confirms that every
// division step leaves a zero remainder.

module catalan_seq_ctrl_chk #(
  parameter int AW = 10
) (
  input logic          clk,
  input logic          rst,
  input logic          chk_en,
  input logic [AW-1:0] rem
);
  // The recurrence always divides exactly, so the remainder is zero by the check cycle.
  a_rem_zero: assert property (@(posedge clk) disable iff (rst) chk_en |-> (rem == '0));
endmodule

module catalan_seq_ctrl #(
  parameter int W  = 128,
  parameter int NW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          ovf
);
  localparam int PW = W + NW + 3;          // holds C(k)*(4k+2) exactly
  localparam int AW = NW + 3;              // width of 4k+2 and k+2
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_CHK, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [NW-1:0]  n_q, n_d;
  logic [NW-1:0]  k_q, k_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [PW-1:0]  quo_q, quo_d;            // dividend shifted out, quotient shifted in
  logic [AW-1:0]  rem_q, rem_d;
  logic [AW-1:0]  dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [AW-1:0]  mul_s;
  logic [AW-1:0]  dvs_s;
  logic [PW-1:0]  prod_s;
  logic [AW:0]    rem_sh_s;
  logic           ge_s;
  logic [AW-1:0]  rem_nx_s;
  logic [NW:0]    k_inc_s;
  logic           last_s;
  logic           q_hi_s;

  assign mul_s    = {1'b0, k_q, 2'b10};                       // 4k+2
  assign dvs_s    = {{(AW-NW){1'b0}}, k_q} + {{(AW-2){1'b0}}, 2'b10};
  assign prod_s   = {{(PW-W){1'b0}}, acc_q} * {{(PW-AW){1'b0}}, mul_s};
  // Restoring step: bring down the next dividend bit and subtract if it fits.
  assign rem_sh_s = {rem_q, quo_q[PW-1]};
  assign ge_s     = rem_sh_s >= {1'b0, dvs_q};
  assign rem_nx_s = ge_s ? AW'(rem_sh_s - {1'b0, dvs_q}) : rem_sh_s[AW-1:0];
  assign k_inc_s  = {1'b0, k_q} + {{NW{1'b0}}, 1'b1};
  assign last_s   = (k_inc_s == {1'b0, n_q});
  assign q_hi_s   = |quo_q[PW-1:W];

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = n;
          k_d   = '0;
          acc_d = {{(W-1){1'b0}}, 1'b1};
          ovf_d = 1'b0;
          if (n == '0) begin
            result_d = {{(W-1){1'b0}}, 1'b1};   // C(0)
            state_d  = S_DONE;
          end else begin
            result_d = '0;
            state_d  = S_MUL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        quo_d   = prod_s;
        dvs_d   = dvs_s;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        quo_d = {quo_q[PW-2:0], ge_s};
        rem_d = rem_nx_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(PW - 1)) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DIV;
        end
      end
      S_CHK: begin
        if (q_hi_s) begin
          ovf_d    = 1'b1;
          result_d = '1;
          state_d  = S_DONE;
        end else begin
          acc_d = quo_q[W-1:0];
          k_d   = k_inc_s[NW-1:0];
          if (last_s) begin
            result_d = quo_q[W-1:0];
            state_d  = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // busy and done are decoded from the next state so that they come out of registers.
    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_CHK);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

  catalan_seq_ctrl_chk #(.AW(AW)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .chk_en (state_q == S_CHK),
    .rem    (rem_q)
  );
endmodule
